wb_uart_hex: RTL and testbench
==============================

WB_UART_HEX -- requirements
Module: wb_uart_hex

Interface
REQ-001 Parameter WB_ADDR_BITS, default 32, SHALL set the master address width.
REQ-002 Parameter UART_ADDR, default 0, SHALL be the constant address driven on every write.
REQ-003 i_wb_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_wb_rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_start  in  1  SHALL be a one-cycle request to print i_word.
REQ-006 i_word  in  32  SHALL be the value to print, sampled only on an accepted start.
REQ-007 o_busy  out  1  SHALL be high from the cycle after an accepted start until o_done.
REQ-008 o_done  out  1  SHALL pulse high one cycle when the last character is acknowledged.
REQ-009 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  SHALL be Wishbone B4 pipelined master controls.
REQ-010 o_wb_addr  out  WB_ADDR_BITS  SHALL always equal UART_ADDR.
REQ-011 o_wb_data  out  32  SHALL carry the character in [7:0]; bits [31:8] SHALL be 0.
REQ-012 i_wb_stall, i_wb_ack  in  1 each  SHALL be the slave's stall and ack.

Function
REQ-013 States IDLE, REQ, WAIT, SHALL be the only FSM states.
REQ-014 IDLE: i_start=1 SHALL latch i_word, clear char index to 0, go to REQ next cycle.
REQ-015 REQ: cyc=stb=we=1, data=current char; i_wb_stall=0 in a cycle SHALL transfer the request and go to WAIT (stb low next cycle); stall=1 SHALL hold REQ with data unchanged.
REQ-016 WAIT: cyc=1, stb=0; i_wb_ack=1 SHALL advance index and go to REQ, or to IDLE with o_done=1 after the final char.
REQ-017 Ack arriving in the same cycle as the unstalled request SHALL be counted; FSM then skips WAIT.
REQ-018 Acks outside REQ/WAIT SHALL be ignored; no more than one request SHALL be outstanding.
REQ-019 Chars SHALL be nibbles of the latched word, most significant first, index 0..7.
REQ-020 Nibble n<10 SHALL map to 0x30+n; n>=10 SHALL map to 0x61+(n-10) (lowercase).
REQ-021 o_wb_cyc SHALL drop for at least one cycle between characters (per-character cycles).
REQ-022 i_start while o_busy=1 SHALL be ignored; i_word changes mid-print SHALL have no effect.
REQ-023 No timeout: a slave that never acks SHALL hold the FSM in WAIT indefinitely.
REQ-024 Minimum throughput with zero stall and ack on the next cycle SHALL be one char per 3 cycles.

Reset
REQ-025 Asserting i_wb_rst SHALL immediately force IDLE, index 0, o_wb_cyc=o_wb_stb=o_wb_we=0, o_busy=0, o_done=0, o_wb_data=0.
REQ-026 Reset mid-print SHALL abandon the string; no char SHALL be resent after release.
REQ-027 First i_start SHALL be honoured on the first clock edge after reset deasserts.

Configuration
REQ-028 Macro WB_UART_HEX_NEWLINE_EN defined SHALL append 0x0D then 0x0A after the 8 hex chars (10 writes, index 0..9).
REQ-029 Without WB_UART_HEX_NEWLINE_EN exactly 8 writes SHALL be issued and o_done SHALL follow the 8th ack.

Verification
REQ-030 Macro on, i_word=0xDEADBEEF, no stall, ack next cycle -> data 0x64,0x65,0x61,0x64,0x62,0x65,0x65,0x66,0x0D,0x0A, one o_done pulse.
REQ-031 i_word=0x0123456F, i_wb_stall held 5 cycles on 1st char -> stb high 6 cycles, data 0x30 stable, then 0x31..0x36,0x66.
REQ-032 Second i_start with 0x00000000 during print of 0xFFFFFFFF -> only 'f' (0x66) x8 observed, no extra writes.
REQ-033 Reset asserted in WAIT after 3rd char -> cyc/stb low same cycle, o_busy=0; new start 0x000000A5 prints from index 0.
REQ-034 Ack combinational with unstalled stb every char -> 2-cycle char spacing, correct string, o_done once.
REQ-035 Macro off, i_word=0x89ABCDEF -> exactly 8 writes 0x38,0x39,0x61,0x62,0x63,0x64,0x65,0x66, o_wb_data[31:8]=0 throughout.

Source files
------------

// File: rtl/wb_uart_hex.sv
// ============================================================================
// Module   : wb_uart_hex
// Purpose  : Prints a 32-bit word as eight lowercase hex characters, most
//            significant nibble first. Each character is sent as a single
//            Wishbone B4 pipelined write to a fixed UART address.
// Options  : define WB_UART_HEX_NEWLINE_EN to append CR (0x0D) and LF (0x0A).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_uart_hex #(
    parameter int                      WB_ADDR_BITS = 32,
    parameter logic [WB_ADDR_BITS-1:0] UART_ADDR    = '0
) (
    input  logic                    i_wb_clk,
    input  logic                    i_wb_rst,
    input  logic                    i_start,
    input  logic [31:0]             i_word,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [WB_ADDR_BITS-1:0] o_wb_addr,
    output logic [31:0]             o_wb_data,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

`ifdef WB_UART_HEX_NEWLINE_EN
    localparam logic [3:0] c_LAST_IDX = 4'd9;
`else
    localparam logic [3:0] c_LAST_IDX = 4'd7;
`endif

    logic [1:0]  r_state;
    logic [31:0] r_word;
    logic [3:0]  r_idx;
    logic        r_gap;
    logic        r_done;

    logic [31:0] w_shifted;
    logic [3:0]  w_nibble;
    logic [7:0]  w_char;
    logic        w_take_ack;
    logic        w_last;

    always_comb begin
        w_shifted = r_word << {r_idx[2:0], 2'b00};
        w_nibble  = w_shifted[31:28];
        if (w_nibble < 4'd10) begin
            w_char = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_char = 8'h57 + {4'h0, w_nibble};
        end
`ifdef WB_UART_HEX_NEWLINE_EN
        if (r_idx[3]) begin
            w_char = r_idx[0] ? 8'h0A : 8'h0D;
        end
`endif
    end

    // r_gap holds the bus idle for one cycle so every character is its own cycle
    assign o_wb_stb  = (r_state == c_REQ) && !r_gap;
    assign o_wb_cyc  = o_wb_stb || (r_state == c_WAIT);
    assign o_wb_we   = o_wb_cyc;
    assign o_wb_addr = UART_ADDR;
    assign o_wb_data = o_wb_cyc ? {24'h0, w_char} : 32'h0;
    assign o_busy    = (r_state != c_IDLE);
    assign o_done    = r_done;

    // An ack alongside the unstalled strobe completes the character at once
    assign w_take_ack = i_wb_ack && ((o_wb_stb && !i_wb_stall) || (r_state == c_WAIT));
    assign w_last     = (r_idx == c_LAST_IDX);

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            r_state <= c_IDLE;
            r_word  <= 32'h0;
            r_idx   <= 4'd0;
            r_gap   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_take_ack) begin
                if (w_last) begin
                    r_state <= c_IDLE;
                    r_idx   <= 4'd0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= c_REQ;
                    r_idx   <= r_idx + 4'd1;
                    r_gap   <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (i_start) begin
                            r_word  <= i_word;
                            r_idx   <= 4'd0;
                            r_gap   <= 1'b0;
                            r_state <= c_REQ;
                        end
                    end
                    c_REQ: begin
                        if (r_gap) begin
                            r_gap <= 1'b0;
                        end else if (!i_wb_stall) begin
                            r_state <= c_WAIT;
                        end
                    end
                    c_WAIT: begin
                        r_state <= c_WAIT;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_uart_hex.sv
// ============================================================================
// Module   : tb_wb_uart_hex
// Purpose  : Scoreboard bench for wb_uart_hex with a randomised Wishbone slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_uart_hex;

    localparam int          AW   = 32;
    localparam logic [31:0] ADDR = 32'h1000_0004;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] word;
    logic        busy;
    logic        done;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        stall;
    logic        ack;
    logic        ack_dly;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         done_q[$];

    // Slave behaviour knobs, set by the stimulus process
    logic comb_mode   = 1'b0;
    int   stall_pct   = 0;
    int   lat_min     = 1;
    int   lat_max     = 1;
    int   force_stall = 0;
    int   exp_spacing = 0;

    // Monitor state
    int   chars      = 0;
    int   cyc_n      = 0;
    int   last_xfer  = 0;
    logic outstanding = 1'b0;
    logic acked_since_low = 1'b0;

    wb_uart_hex #(
        .WB_ADDR_BITS(AW),
        .UART_ADDR   (ADDR)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_start   (start),
        .i_word    (word),
        .o_busy    (busy),
        .o_done    (done),
        .o_wb_cyc  (cyc),
        .o_wb_stb  (stb),
        .o_wb_we   (we),
        .o_wb_addr (addr),
        .o_wb_data (data),
        .i_wb_stall(stall),
        .i_wb_ack  (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ack = ack_dly | (comb_mode & stb & ~stall);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: observed %h", name, act);
    endtask

    // Reference model: the printed text is just the word formatted as hex
    task automatic push_word(input logic [31:0] w);
        string s;
        s = $sformatf("%08h", w);
        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
`ifdef WB_UART_HEX_NEWLINE_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        done_q.push_back(10);
`else
        done_q.push_back(8);
`endif
    endtask

    task automatic issue(input logic [31:0] w);
        @(negedge clk); #1;
        start = 1'b1;
        word  = w;
        push_word(w);
        @(posedge clk); #1;
        start = 1'b0;
        word  = $urandom;
        chk("busy after start", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_q.size() != 0) begin
            bad("print timeout", done_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    // Wishbone slave: random stall, random ack latency, optional same-cycle ack
    initial begin : slave
        int   cnt;
        logic pend;
        cnt     = 0;
        pend    = 1'b0;
        stall   = 1'b0;
        ack_dly = 1'b0;
        forever begin
            @(negedge clk); #1;
            ack_dly = 1'b0;
            if (rst) begin
                pend  = 1'b0;
                stall = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        ack_dly = 1'b1;
                        pend    = 1'b0;
                    end
                end
                if (force_stall > 0 && stb) begin
                    stall = 1'b1;
                    force_stall--;
                end else begin
                    stall = ($urandom_range(99) < stall_pct);
                end
                if (stb && !stall && !comb_mode) begin
                    pend = 1'b1;
                    cnt  = $urandom_range(lat_max, lat_min);
                end
                if (!cyc && !ack_dly && $urandom_range(9) == 0) ack_dly = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted write and on o_done
    initial begin : monitor
        logic [7:0] e;
        int         n;
        forever begin
            @(negedge clk); #2;
            cyc_n++;
            if (rst) begin
                outstanding     = 1'b0;
                acked_since_low = 1'b0;
                chars           = 0;
            end else begin
                if (cyc && stb) begin
                    chk("bus controls", {we, data[31:8], addr == ADDR}, {1'b1, 24'h0, 1'b1});
                    if (exp_q.size() == 0) begin
                        bad("unexpected write", data);
                    end else if (stall) begin
                        chk("stalled data", {24'h0, data[7:0]}, {24'h0, exp_q[0]});
                    end else begin
                        e = exp_q.pop_front();
                        chk("char", data, {24'h0, e});
                        if (outstanding) bad("second outstanding request", data);
                        if (acked_since_low) bad("no cyc gap between chars", data);
                        if (exp_spacing != 0 && chars > 0)
                            chk("char spacing", cyc_n - last_xfer, exp_spacing);
                        last_xfer   = cyc_n;
                        chars++;
                        outstanding = 1'b1;
                    end
                end
                if (ack && cyc && outstanding) begin
                    outstanding     = 1'b0;
                    acked_since_low = 1'b1;
                end
                if (!cyc) acked_since_low = 1'b0;
                if (done) begin
                    if (done_q.size() == 0) begin
                        bad("unexpected done", chars);
                    end else begin
                        n = done_q.pop_front();
                        chk("chars per print", chars, n);
                    end
                    chars = 0;
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst   = 1'b1;
        start = 1'b0;
        word  = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset cyc/stb/we", {cyc, stb, we}, 3'b000);
        chk("reset busy/done", {busy, done}, 2'b00);
        chk("reset data", data, 32'h0);
        chk("addr constant", addr, ADDR);

        // First start on the very first edge after reset release
        exp_spacing = 3;
        @(negedge clk); #1;
        rst   = 1'b0;
        start = 1'b1;
        word  = 32'hDEAD_BEEF;
        push_word(32'hDEAD_BEEF);
        @(posedge clk); #1;
        start = 1'b0;
        word  = $urandom;
        chk("busy after first start", {31'h0, busy}, 32'h1);
        wait_done();

        // Five stalled cycles on the first character
        exp_spacing = 0;
        force_stall = 5;
        issue(32'h0123_456F);
        wait_done();
        chk("forced stalls consumed", force_stall, 0);

        // Start while busy is ignored
        exp_spacing = 3;
        issue(32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1;
        word  = 32'h0;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done();

        issue(32'h89AB_CDEF);
        wait_done();

        // Same-cycle ack: two cycles per character
        comb_mode   = 1'b1;
        exp_spacing = 2;
        for (int i = 0; i < 3; i++) begin
            issue($urandom);
            wait_done();
        end
        comb_mode   = 1'b0;

        // Reset while waiting for the third ack
        exp_spacing = 0;
        lat_min     = 3;
        lat_max     = 3;
        issue($urandom);
        n = 0;
        while (chars < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (chars < 3) bad("third char timeout", chars);
        #1;
        rst = 1'b1;
        #1;
        chk("reset mid-print cyc/stb", {cyc, stb}, 2'b00);
        chk("reset mid-print busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        done_q.delete();
        @(negedge clk); #1;
        lat_min = 1;
        lat_max = 1;
        rst   = 1'b0;
        start = 1'b1;
        word  = 32'h0000_00A5;
        push_word(32'h0000_00A5);
        @(posedge clk); #1;
        start = 1'b0;
        word  = $urandom;
        chk("busy after restart", {31'h0, busy}, 32'h1);
        wait_done();

        // Randomised slave timing
        for (int i = 0; i < 24; i++) begin
            comb_mode = ($urandom_range(3) == 0);
            stall_pct = $urandom_range(40);
            lat_max   = $urandom_range(3, 1);
            issue($urandom);
            wait_done();
        end
        comb_mode = 1'b0;
        stall_pct = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
